// File: rtl/picorv_fabric_pkg.sv
// Shared definitions for the picorv32 memory fabric: FSM encoding, MMIO offsets,
// the unmapped-access read pattern and STATUS register bit positions.
package picorv_fabric_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STALL,
    S_RESP
  } fabric_state_t;

  localparam logic [11:0] TX_STRIDE   = 12'd4;
  localparam logic [11:0] STATUS_OFS  = 12'h040;
  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  localparam int ST_FULL_LSB  = 0;
  localparam int ST_EMPTY_LSB = 8;
  localparam int ST_ERR_BIT   = 16;
  localparam int ST_CLR_BIT   = 16;

endpackage

// File: rtl/picorv_byte_fifo.sv
// Byte FIFO with registered full/empty flags and no fall-through; pushes while
// full and pops while empty are ignored.
module picorv_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (32'(count) == DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? 8'h00 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/picorv_mem_fabric.sv
// picorv32 native-bus slave: wait-stated RAM, OUT_CHANNELS flow-controlled byte FIFOs and a STATUS register.
// Define PICORV_FABRIC_ERR_EN to make unmapped accesses return ERR_PATTERN and raise the sticky bus_err.
module picorv_mem_fabric
  import picorv_fabric_pkg::*;
#(
  parameter int          MEM_WORDS    = 4096,
  parameter string       INIT_FILE    = "firmware.hex",
  parameter int          WAIT_STATES  = 0,
  parameter int          OUT_CHANNELS = 2,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] MMIO_BASE    = 32'h1000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_valid,
  input  logic                      mem_instr,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic [3:0]                mem_wstrb,
  output logic                      mem_ready,
  output logic [31:0]               mem_rdata,
  output logic [8*OUT_CHANNELS-1:0] out_data,
  output logic [OUT_CHANNELS-1:0]   out_valid,
  input  logic [OUT_CHANNELS-1:0]   out_ready,
  output logic                      bus_err
);
  localparam int MAW = $clog2(MEM_WORDS);
`ifdef PICORV_FABRIC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [31:0] UNMAPPED_RDATA = ERR_EN ? ERR_PATTERN : 32'h0;

  fabric_state_t state;
  logic [3:0]    wait_cnt;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          err_q;
  logic [31:0]   ram [MEM_WORDS];

  logic [31:0]   dec_addr;
  logic [31:0]   dec_wdata;
  logic [3:0]    dec_wstrb;
  logic [11:0]   ofs;
  logic [11:0]   tx_idx;
  logic [2:0]    tx_ch;
  logic [MAW-1:0] ram_idx;
  logic          accept, ram_hit, mmio_hit, tx_hit, status_hit, tx_full, do_push, ram_we;
  logic [OUT_CHANNELS-1:0] fifo_full, fifo_empty, fifo_push;
  logic [7:0]    full_ext, empty_ext;
  logic [31:0]   status_word;
  logic          unused_instr;

  assign unused_instr = mem_instr;

  // Decode the live bus in IDLE and the latched request while waiting or stalled.
  assign accept     = (state == S_IDLE) && mem_valid && !mem_ready;
  assign dec_addr   = (state == S_IDLE) ? mem_addr  : req_addr;
  assign dec_wdata  = (state == S_IDLE) ? mem_wdata : req_wdata;
  assign dec_wstrb  = (state == S_IDLE) ? mem_wstrb : req_wstrb;
  assign ram_hit    = (dec_addr >> 2) < 32'(MEM_WORDS);
  assign ram_idx    = dec_addr[MAW+1:2];
  assign mmio_hit   = (dec_addr[31:12] == MMIO_BASE[31:12]);
  assign ofs        = dec_addr[11:0];
  assign tx_idx     = ofs / TX_STRIDE;
  assign tx_ch      = tx_idx[2:0];
  assign tx_hit     = mmio_hit && (ofs % TX_STRIDE == 12'd0) && (tx_idx < 12'(OUT_CHANNELS))
                      && (dec_wstrb != 4'b0000);
  assign status_hit = mmio_hit && (ofs == STATUS_OFS);
  assign full_ext   = 8'(fifo_full);
  assign empty_ext  = 8'(fifo_empty);
  assign tx_full    = full_ext[tx_ch];
  assign do_push    = tx_hit && !tx_full && (accept || state == S_STALL);
  assign ram_we     = !reset && ram_hit && (dec_wstrb != 4'b0000)
                      && ((accept && WAIT_STATES == 0) || (state == S_WAIT && wait_cnt == 4'd1));
  assign out_valid  = ~fifo_empty;
  assign bus_err    = err_q;

  always_comb begin
    status_word                      = '0;
    status_word[ST_FULL_LSB +: 8]    = full_ext;
    status_word[ST_EMPTY_LSB +: 8]   = empty_ext;
    status_word[ST_ERR_BIT]          = err_q;
  end

  for (genvar k = 0; k < OUT_CHANNELS; k++) begin : g_ch
    assign fifo_push[k] = do_push && (tx_ch == 3'(k));
    picorv_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push[k]),
      .din   (dec_wdata[7:0]),
      .full  (fifo_full[k]),
      .pop   (out_valid[k] && out_ready[k]),
      .dout  (out_data[8*k +: 8]),
      .empty (fifo_empty[k])
    );
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dec_wstrb[b]) begin
          ram[ram_idx][8*b +: 8] <= dec_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      wait_cnt  <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      err_q     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
            if (ram_hit) begin
              if (WAIT_STATES == 0) begin
                mem_rdata <= ram[ram_idx];
                mem_ready <= 1'b1;
                state     <= S_RESP;
              end else begin
                wait_cnt <= 4'(WAIT_STATES);
                state    <= S_WAIT;
              end
            end else if (tx_hit) begin
              if (tx_full) begin
                state <= S_STALL;
              end else begin
                mem_rdata <= '0;
                mem_ready <= 1'b1;
                state     <= S_RESP;
              end
            end else if (status_hit) begin
              mem_rdata <= (mem_wstrb == 4'b0000) ? status_word : 32'h0;
`ifdef PICORV_FABRIC_ERR_EN
              if (mem_wstrb != 4'b0000 && mem_wdata[ST_CLR_BIT]) begin
                err_q <= 1'b0;
              end
`endif
              mem_ready <= 1'b1;
              state     <= S_RESP;
            end else begin
              mem_rdata <= UNMAPPED_RDATA;
`ifdef PICORV_FABRIC_ERR_EN
              err_q <= 1'b1;
`endif
              mem_ready <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            mem_rdata <= ram[ram_idx];
            mem_ready <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        // full is registered, so a pop only frees the slot one cycle later.
        S_STALL: begin
          if (!tx_full) begin
            mem_rdata <= '0;
            mem_ready <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
